// File: rtl/branch_predictor.sv
// Direct-mapped, tagless branch predictor: 2-bit saturating counters with a
// valid bit and a stored target per entry, a zero-cycle fetch lookup, an
// execute-stage misprediction check and saturating branch statistics.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCF,
  output logic             PredTakenF,
  output logic [31:0]      PredTargetF,
  input  logic             BranchE,
  input  logic             BranchTakenE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      TargetE,
  input  logic             PredTakenE,
  input  logic [31:0]      PredTargetE,
  output logic             MispredictE,
  output logic [31:0]      RedirectPCE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic [1:0]          r_cnt [ENTRIES];
  logic                r_vld [ENTRIES];
  logic [31:0]         r_tgt [ENTRIES];
  logic [CNT_W-1:0]    r_branch_cnt;
  logic [CNT_W-1:0]    r_mispred_cnt;

  logic [IDX_BITS-1:0] w_fidx;
  logic [IDX_BITS-1:0] w_eidx;
  logic                w_tgt_wrong;

  assign w_fidx = PCF[IDX_BITS+1:2];
  assign w_eidx = PCE[IDX_BITS+1:2];

  // Fetch lookup reads registered state only, so a same-cycle update to the
  // same entry is seen by fetch one cycle later.
  assign PredTakenF  = r_vld[w_fidx] & r_cnt[w_fidx][1];
  assign PredTargetF = PredTakenF ? r_tgt[w_fidx] : PCF + 32'd4;

  assign w_tgt_wrong = BranchTakenE & PredTakenE & (PredTargetE != TargetE);
  assign MispredictE = BranchE & ((BranchTakenE != PredTakenE) | w_tgt_wrong);
  assign RedirectPCE = BranchTakenE ? TargetE : PCE + 32'd4;

  assign BranchCount     = r_branch_cnt;
  assign MispredictCount = r_mispred_cnt;

  // Table update: train the counter on every resolved branch, capture the
  // target (and mark valid) only when the branch was taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= 2'b01;
        r_vld[i] <= 1'b0;
        r_tgt[i] <= '0;
      end
    end else if (BranchE) begin
      if (BranchTakenE) begin
        if (r_cnt[w_eidx] != 2'b11) r_cnt[w_eidx] <= r_cnt[w_eidx] + 2'd1;
        r_tgt[w_eidx] <= TargetE;
        r_vld[w_eidx] <= 1'b1;
      end else begin
        if (r_cnt[w_eidx] != 2'b00) r_cnt[w_eidx] <= r_cnt[w_eidx] - 2'd1;
      end
    end
  end

  // Statistics: saturating counts of resolved branches and mispredictions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (BranchE && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (MispredictE && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard-driven bench for branch_predictor: expectations are queued when
// stimulus is applied and compared when the DUT output is sampled.
module tb_branch_predictor;

  localparam int unsigned CW = 8;

  logic          clk;
  logic          reset;
  logic [31:0]   PCF;
  logic          PredTakenF;
  logic [31:0]   PredTargetF;
  logic          BranchE;
  logic          BranchTakenE;
  logic [31:0]   PCE;
  logic [31:0]   TargetE;
  logic          PredTakenE;
  logic [31:0]   PredTargetE;
  logic          MispredictE;
  logic [31:0]   RedirectPCE;
  logic [CW-1:0] BranchCount;
  logic [CW-1:0] MispredictCount;

  int            n_tests;
  int            n_fail;
  logic [31:0]   exp_q[$];
  logic [31:0]   exp;

  branch_predictor #(.IDX_BITS(4), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .PCF             (PCF),
    .PredTakenF      (PredTakenF),
    .PredTargetF     (PredTargetF),
    .BranchE         (BranchE),
    .BranchTakenE    (BranchTakenE),
    .PCE             (PCE),
    .TargetE         (TargetE),
    .PredTakenE      (PredTakenE),
    .PredTargetE     (PredTargetE),
    .MispredictE     (MispredictE),
    .RedirectPCE     (RedirectPCE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    BranchE      = 1'b1;
    BranchTakenE = tk;
    PCE          = pc;
    TargetE      = tgt;
    PredTakenE   = ptk;
    PredTargetE  = ptgt;
  endtask

  task automatic idle();
    BranchE      = 1'b0;
    BranchTakenE = 1'b0;
    PCE          = '0;
    TargetE      = '0;
    PredTakenE   = 1'b0;
    PredTargetE  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    PCF = 32'h100;
    repeat (2) @(posedge clk);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h104);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL in_reset_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL in_reset_tgt: got %h want %h", PredTargetF, exp); end
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    tick();
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL reset_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL reset_tgt: got %h want %h", PredTargetF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL reset_bc: got %0d want %0d", BranchCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictCount) !== exp) begin n_fail++; $display("FAIL reset_mc: got %0d want %0d", MispredictCount, exp); end
  endtask

  task automatic test_first_update();
    drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    PCF = 32'h100;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'd0);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictE) !== exp) begin n_fail++; $display("FAIL first_misp: got %h want %h", MispredictE, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (RedirectPCE !== exp) begin n_fail++; $display("FAIL first_redirect: got %h want %h", RedirectPCE, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL first_no_bypass: got %h want %h", PredTakenF, exp); end
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    tick();
    idle();
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL first_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL first_tgt: got %h want %h", PredTargetF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL first_bc: got %0d want %0d", BranchCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictCount) !== exp) begin n_fail++; $display("FAIL first_mc: got %0d want %0d", MispredictCount, exp); end
  endtask

  // Entry 0 starts at 2'b10: 4 taken saturate to 11, then three not-taken
  // walk it down to 00.
  task automatic test_hysteresis();
    PCF = 32'h100;
    for (int i = 0; i < 4; i++) begin
      drive_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      tick();
    end
    drive_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h200);
    tick();
    idle();
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL hyst_10_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL hyst_10_tgt: got %h want %h", PredTargetF, exp); end
    drive_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    exp_q.push_back(32'd0);
    tick();
    idle();
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL hyst_01_pt: got %h want %h", PredTakenF, exp); end
    drive_upd(32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd3);
    tick();
    idle();
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL hyst_00_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL hyst_00_tgt: got %h want %h", PredTargetF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL hyst_bc: got %0d want %0d", BranchCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictCount) !== exp) begin n_fail++; $display("FAIL hyst_mc: got %0d want %0d", MispredictCount, exp); end
  endtask

  task automatic test_alias();
    for (int i = 0; i < 2; i++) begin
      drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
      tick();
    end
    idle();
    PCF = 32'h140;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h200);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL alias_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL alias_tgt: got %h want %h", PredTargetF, exp); end
    PCF = 32'h144;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h148);
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd5);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL other_idx_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL other_idx_tgt: got %h want %h", PredTargetF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL alias_bc: got %0d want %0d", BranchCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictCount) !== exp) begin n_fail++; $display("FAIL alias_mc: got %0d want %0d", MispredictCount, exp); end
  endtask

  task automatic test_target_mismatch();
    drive_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h300);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h200);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictE) !== exp) begin n_fail++; $display("FAIL tgt_wrong_misp: got %h want %h", MispredictE, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (RedirectPCE !== exp) begin n_fail++; $display("FAIL tgt_wrong_redirect: got %h want %h", RedirectPCE, exp); end
    drive_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h104);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictE) !== exp) begin n_fail++; $display("FAIL nt_misp: got %h want %h", MispredictE, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (RedirectPCE !== exp) begin n_fail++; $display("FAIL nt_redirect: got %h want %h", RedirectPCE, exp); end
    BranchE = 1'b0;
    exp_q.push_back(32'd0);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictE) !== exp) begin n_fail++; $display("FAIL no_branch_misp: got %h want %h", MispredictE, exp); end
    drive_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    exp_q.push_back(32'd0);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictE) !== exp) begin n_fail++; $display("FAIL tgt_match_misp: got %h want %h", MispredictE, exp); end
    exp_q.push_back(32'd11);
    exp_q.push_back(32'd5);
    tick();
    idle();
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL tgt_bc: got %0d want %0d", BranchCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictCount) !== exp) begin n_fail++; $display("FAIL tgt_mc: got %0d want %0d", MispredictCount, exp); end
  endtask

  // Two consecutive updates to entry 1 while fetch looks it up: fetch sees
  // the pre-update state each cycle.
  task automatic test_back_to_back();
    PCF = 32'h104;
    drive_upd(32'h104, 1'b1, 32'h400, 1'b0, 32'h108);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h108);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL b2b_1_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL b2b_1_tgt: got %h want %h", PredTargetF, exp); end
    tick();
    drive_upd(32'h104, 1'b1, 32'h400, 1'b1, 32'h400);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h400);
    exp_q.push_back(32'd0);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL b2b_2_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL b2b_2_tgt: got %h want %h", PredTargetF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictE) !== exp) begin n_fail++; $display("FAIL b2b_2_misp: got %h want %h", MispredictE, exp); end
    exp_q.push_back(32'd13);
    exp_q.push_back(32'd6);
    tick();
    idle();
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL b2b_bc: got %0d want %0d", BranchCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictCount) !== exp) begin n_fail++; $display("FAIL b2b_mc: got %0d want %0d", MispredictCount, exp); end
  endtask

  task automatic test_reset_mid();
    PCF = 32'h100;
    drive_upd(32'h108, 1'b1, 32'h500, 1'b0, 32'h10c);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h200);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL pre_rst_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL pre_rst_tgt: got %h want %h", PredTargetF, exp); end
    reset = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h500);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL async_rst_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL async_rst_tgt: got %h want %h", PredTargetF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL async_rst_bc: got %0d want %0d", BranchCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictCount) !== exp) begin n_fail++; $display("FAIL async_rst_mc: got %0d want %0d", MispredictCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictE) !== exp) begin n_fail++; $display("FAIL rst_misp_comb: got %h want %h", MispredictE, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (RedirectPCE !== exp) begin n_fail++; $display("FAIL rst_redirect_comb: got %h want %h", RedirectPCE, exp); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle();
    PCF = 32'h108;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h10c);
    exp_q.push_back(32'd0);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL discarded_upd_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL discarded_upd_tgt: got %h want %h", PredTargetF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL discarded_upd_bc: got %0d want %0d", BranchCount, exp); end
  endtask

  task automatic test_stat_saturate();
    PCF = 32'h10c;
    for (int i = 0; i < 254; i++) begin
      drive_upd(32'h10c, 1'b1, 32'h600, 1'b0, 32'h110);
      tick();
    end
    idle();
    exp_q.push_back(32'd254);
    exp_q.push_back(32'd254);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL stat_254_bc: got %0d want %0d", BranchCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictCount) !== exp) begin n_fail++; $display("FAIL stat_254_mc: got %0d want %0d", MispredictCount, exp); end
    for (int i = 0; i < 46; i++) begin
      drive_upd(32'h10c, 1'b1, 32'h600, 1'b0, 32'h110);
      tick();
    end
    idle();
    exp_q.push_back(32'd255);
    exp_q.push_back(32'd255);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h600);
    #1;
    n_tests++; exp = exp_q.pop_front();
    if (32'(BranchCount) !== exp) begin n_fail++; $display("FAIL stat_sat_bc: got %0d want %0d", BranchCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(MispredictCount) !== exp) begin n_fail++; $display("FAIL stat_sat_mc: got %0d want %0d", MispredictCount, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (32'(PredTakenF) !== exp) begin n_fail++; $display("FAIL stat_sat_pt: got %h want %h", PredTakenF, exp); end
    n_tests++; exp = exp_q.pop_front();
    if (PredTargetF !== exp) begin n_fail++; $display("FAIL stat_sat_tgt: got %h want %h", PredTargetF, exp); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_first_update();
    test_hysteresis();
    test_alias();
    test_target_mismatch();
    test_back_to_back();
    test_reset_mid();
    test_stat_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
